axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
//  Merges PORTS AXI-stream sources into one stream, e.g. several producers into one axis FIFO.
//  Fair round-robin arbitration with one registered output stage.
//  Packet-aware: with the optional lock feature, a granted source holds the output until its ilast beat.
//  osel tags each beat with its source index for downstream demux or debug.
// PARAMETERS
//  DATA_WIDTH  8  payload width per source
//  PORTS       4  number of sources, 2..16
//  SEL_WIDTH   2  width of osel; must be >= clog2(PORTS)
// PORTS
//  clock   in   1                   single clock, all logic on posedge
//  reset   in   1                   synchronous, active-high
//  idata   in   PORTS*DATA_WIDTH    source i payload = idata[i*DATA_WIDTH +: DATA_WIDTH]
//  ivalid  in   PORTS               per-source valid
//  ilast   in   PORTS               per-source end-of-packet
//  iready  out  PORTS               per-source ready; combinational, at most one bit set
//  odata   out  DATA_WIDTH          registered payload
//  olast   out  1                   registered end-of-packet
//  osel    out  SEL_WIDTH           registered source index of the current output beat
//  ovalid  out  1                   registered valid
//  oready  in   1                   downstream ready
// BEHAVIOUR
//  - Reset (sync, active-high): ovalid=0, olast=0, osel=0, odata=0, state=IDLE, rr_last=PORTS-1 (port 0 wins first).
//  - Reset overrides everything; an undelivered output beat is dropped and a held grant is released.
//  - Define load = !ovalid || oready. A transfer on source i means ivalid[i] && iready[i].
//  - A transfer loads odata/olast/osel and sets ovalid=1. Latency from input transfer to ovalid is 1 cycle.
//  - No transfer with oready=1 clears ovalid. Output registers hold while ovalid && !oready.
//  - Full throughput: one beat per cycle while oready=1.
//  - iready may depend on ivalid. ovalid never depends on oready combinationally.
//  - IDLE state:
//    - Winner w = first index with ivalid set, searching rr_last+1 .. PORTS-1, then 0 .. rr_last.
//    - iready = onehot(w) & {PORTS{load}}; iready = 0 when no ivalid is set or load=0.
//    - On a transfer: rr_last <= w. If !ilast[w] (lock enabled), state <= LOCK and owner <= w.
//  - LOCK state:
//    - iready = onehot(owner) & {PORTS{load}}; all other sources are stalled.
//    - On an owner transfer with ilast=1: state <= IDLE. rr_last is unchanged (already owner).
//    - The owner deasserting ivalid mid-packet keeps LOCK; there is no timeout.
//  - Fairness: every source with ivalid held high is granted within PORTS grants.
//  - Wrap-around: the search from rr_last=PORTS-1 starts at 0. SEL_WIDTH upper bits of osel are 0.
//  - Simultaneous: output drain and new load in the same cycle are allowed (load=1 via oready).
// CONFIGURATION
//  Macro AXIS_ARB_PACKET_LOCK_EN:
//  - Defined: IDLE/LOCK FSM as above; packets are never interleaved.
//  - Undefined: LOCK does not exist; every beat is arbitrated independently in IDLE. ilast passes to olast unchanged.
// STRUCTURE
//  - Package axis_arb_pkg holds:
//    - state encoding ST_IDLE=1'b0 and ST_LOCK=1'b1;
//    - function onehot(idx, PORTS);
//    - parameter checks (SEL_WIDTH >= clog2(PORTS), PORTS >= 2).
//  - Sub-module axis_rr_pick: combinational round-robin picker.
//    - Inputs: req[PORTS], last[SEL_WIDTH].
//    - Outputs: any, win[SEL_WIDTH].
//  - Top level holds the FSM, rr_last, owner and the output register.
// TESTING
//  1. After reset, ivalid=4'b1111, oready=1, all ilast=1, lock enabled:
//     grants 0,1,2,3,0 on consecutive cycles; osel follows one cycle later.
//  2. Lock enabled, port 2 sends 3 beats (ilast on beat 3) while port 0 is continuously valid:
//     osel=2,2,2 then 0; iready[0]=0 throughout the packet.
//  3. Backpressure: oready=0 for 5 cycles with ovalid=1:
//     odata/osel stable, iready=0, no beat lost or duplicated; resume with oready=1.
//  4. Lock disabled, same stimulus as 2:
//     osel alternates 2,0,2,0,2; olast appears only on port 2's third beat.
//  5. Assert reset mid-packet (LOCK, ovalid=1):
//     next cycle ovalid=0, state IDLE, the first grant goes to the lowest valid index.
//  6. Only port 3 valid, PORTS=4:
//     it is granted every cycle (rr_last=3 wraps to 3); throughput is 1 beat/cycle.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
// Shared definitions for the AXI-stream round-robin arbiter:
//   - state_t  : arbiter FSM encoding (IDLE / LOCK)
//   - onehot() : index -> one-hot grant vector (up to MAX_PORTS wide)
//   - params_ok(): elaboration-time parameter sanity check
// ---------------------------------------------------------------------------
package axis_arb_pkg;

  localparam int MAX_PORTS = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Out-of-range indices produce an all-zero vector so a bad index never
  // grants a non-existent port.
  function automatic logic [MAX_PORTS-1:0] onehot(input int idx, input int ports);
    logic [MAX_PORTS-1:0] r;
    r = '0;
    if (idx >= 0 && idx < ports && idx < MAX_PORTS) begin
      r = {{(MAX_PORTS-1){1'b0}}, 1'b1} << idx;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int ports, input int sel_width);
    return (ports >= 2) && (ports <= MAX_PORTS) && (sel_width >= $clog2(ports));
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_rr_pick
// Combinational round-robin picker. Returns the first requesting index
// searching last+1 .. PORTS-1, then 0 .. last.
// Ports:
//   req  [PORTS]      request vector
//   last [SEL_WIDTH]  index granted most recently
//   any               at least one request present
//   win  [SEL_WIDTH]  winning index (0 when any=0)
// ---------------------------------------------------------------------------
module axis_rr_pick #(
  parameter int PORTS     = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [PORTS-1:0]     req,
  input  logic [SEL_WIDTH-1:0] last,
  output logic                 any,
  output logic [SEL_WIDTH-1:0] win
);

  logic                 hi_found;
  logic [SEL_WIDTH-1:0] hi_idx;
  logic [SEL_WIDTH-1:0] lo_idx;

  // Scan downwards so the final assignment in each class is the lowest
  // index: hi_idx = lowest request above last, lo_idx = lowest request
  // overall (the wrap-around candidate).
  always_comb begin
    any      = |req;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = SEL_WIDTH'(i);
        if (i > int'(last)) begin
          hi_found = 1'b1;
          hi_idx   = SEL_WIDTH'(i);
        end
      end
    end
    win = hi_found ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
// Merges PORTS AXI-stream sources into one registered output stream using
// fair round-robin arbitration. osel tags each beat with its source index.
//
// Optional feature macro: AXIS_ARB_PACKET_LOCK_EN
//   defined   : a source granted mid-packet owns the output until its ilast
//               beat (IDLE/LOCK FSM); packets never interleave.
//   undefined : every beat is arbitrated independently.
//
// Ports:
//   clock            single clock, posedge
//   reset            synchronous, active-high
//   idata  [P*DW]    source i payload = idata[i*DATA_WIDTH +: DATA_WIDTH]
//   ivalid [P]       per-source valid
//   ilast  [P]       per-source end-of-packet
//   iready [P]       per-source ready, combinational, at most one bit set
//   odata  [DW]      registered payload
//   olast            registered end-of-packet
//   osel   [SW]      registered source index of the output beat
//   ovalid           registered valid
//   oready           downstream ready
// ---------------------------------------------------------------------------
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int PORTS      = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PORTS*DATA_WIDTH-1:0] idata,
  input  logic [PORTS-1:0]            ivalid,
  input  logic [PORTS-1:0]            ilast,
  output logic [PORTS-1:0]            iready,
  output logic [DATA_WIDTH-1:0]       odata,
  output logic                        olast,
  output logic [SEL_WIDTH-1:0]        osel,
  output logic                        ovalid,
  input  logic                        oready
);

  import axis_arb_pkg::*;

  if (!params_ok(PORTS, SEL_WIDTH)) begin : g_param_check
    $error("axis_rr_arbiter: need 2 <= PORTS <= 16 and SEL_WIDTH >= clog2(PORTS)");
  end

  logic                  load;
  logic                  xfer;
  logic                  pick_any;
  logic [SEL_WIDTH-1:0]  pick_win;
  logic [SEL_WIDTH-1:0]  rr_last;
  logic [SEL_WIDTH-1:0]  target;
  logic                  target_ok;
  logic [PORTS-1:0]      grant;
  logic [DATA_WIDTH-1:0] data_mux;
  logic                  last_mux;

  logic [DATA_WIDTH-1:0] data_p1;
  logic                  last_p1;
  logic [SEL_WIDTH-1:0]  sel_p1;
  logic                  vld_p1;

`ifdef AXIS_ARB_PACKET_LOCK_EN
  state_t               state, state_next;
  logic [SEL_WIDTH-1:0] owner, owner_next;
`endif

  axis_rr_pick #(
    .PORTS     (PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_pick (
    .req  (ivalid),
    .last (rr_last),
    .any  (pick_any),
    .win  (pick_win)
  );

  // The output register can take a new beat when empty or being drained.
  assign load = !vld_p1 || oready;

  // In LOCK the owner is offered ready even while its valid is low, so a
  // stalled packet simply resumes; nobody else can sneak in.
  always_comb begin
    target    = pick_win;
    target_ok = pick_any;
`ifdef AXIS_ARB_PACKET_LOCK_EN
    if (state == ST_LOCK) begin
      target    = owner;
      target_ok = 1'b1;
    end
`endif
  end

  always_comb begin
    grant = '0;
    if (target_ok && load) begin
      grant = PORTS'(onehot(int'(target), PORTS));
    end
  end

  assign iready = grant;
  assign xfer   = |(ivalid & grant);

  always_comb begin
    data_mux = '0;
    last_mux = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (i == int'(target)) begin
        data_mux = idata[i*DATA_WIDTH +: DATA_WIDTH];
        last_mux = ilast[i];
      end
    end
  end

  // rr_last only moves on a transfer; in LOCK target == owner == rr_last.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last <= SEL_WIDTH'(PORTS - 1);
    end else if (xfer) begin
      rr_last <= target;
    end
  end

`ifdef AXIS_ARB_PACKET_LOCK_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      owner <= '0;
    end else begin
      state <= state_next;
      owner <= owner_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    if (xfer) begin
      case (state)
        ST_IDLE: begin
          if (!last_mux) begin
            state_next = ST_LOCK;
            owner_next = target;
          end
        end
        ST_LOCK: begin
          if (last_mux) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end
`endif

  // ---- output register stage (p1) ----
  always_ff @(posedge clock) begin
    if (reset) begin
      data_p1 <= '0;
      last_p1 <= 1'b0;
      sel_p1  <= '0;
      vld_p1  <= 1'b0;
    end else if (xfer) begin
      data_p1 <= data_mux;
      last_p1 <= last_mux;
      sel_p1  <= target;
      vld_p1  <= 1'b1;
    end else if (oready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign odata  = data_p1;
  assign olast  = last_p1;
  assign osel   = sel_p1;
  assign ovalid = vld_p1;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
// Directed self-checking bench for axis_rr_arbiter (DATA_WIDTH=8, PORTS=4,
// SEL_WIDTH=2). Expected values are hand-derived; the packet scenario uses
// the expectations matching the AXIS_ARB_PACKET_LOCK_EN setting.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int SW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NP*DW-1:0] idata;
  logic [NP-1:0]    ivalid;
  logic [NP-1:0]    ilast;
  logic [NP-1:0]    iready;
  logic [DW-1:0]    odata;
  logic             olast;
  logic [SW-1:0]    osel;
  logic             ovalid;
  logic             oready;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  axis_rr_arbiter #(
    .DATA_WIDTH (DW),
    .PORTS      (NP),
    .SEL_WIDTH  (SW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .idata  (idata),
    .ivalid (ivalid),
    .ilast  (ilast),
    .iready (iready),
    .odata  (odata),
    .olast  (olast),
    .osel   (osel),
    .ovalid (ovalid),
    .oready (oready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int p, input logic [DW-1:0] v);
    idata[p*DW +: DW] = v;
  endtask

  task automatic chk_ready(input string tag, input logic [NP-1:0] exp);
    #1;
    chk(tag, 32'(iready), 32'(exp));
  endtask

  task automatic chk_out(input string tag, input logic [SW-1:0] s, input logic [DW-1:0] d,
                         input logic l, input logic v);
    chk({tag, "_osel"},   32'(osel),   32'(s));
    chk({tag, "_odata"},  32'(odata),  32'(d));
    chk({tag, "_olast"},  32'(olast),  32'(l));
    chk({tag, "_ovalid"}, 32'(ovalid), 32'(v));
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    idata  = '0;
    ivalid = '0;
    ilast  = '0;
    oready = 1'b0;
    tick;
    tick;
    reset = 1'b0;

    // Reset state
    chk_out("rst", 2'd0, 8'h00, 1'b0, 1'b0);
    chk_ready("rst_ready", 4'b0000);

    // All four sources valid, single-beat packets: 0,1,2,3,0
    for (int p = 0; p < NP; p++) set_data(p, 8'(8'h11 * p));
    ivalid = 4'b1111;
    ilast  = 4'b1111;
    oready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk_ready($sformatf("rr%0d_ready", k), 4'(4'b0001 << (k % 4)));
      tick;
      chk_out($sformatf("rr%0d", k), 2'(k % 4), 8'(8'h11 * (k % 4)), 1'b1, 1'b1);
    end

    // Backpressure: beat from port 0 is held for 5 cycles
    oready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk_ready($sformatf("bp%0d_ready", k), 4'b0000);
      tick;
      chk_out($sformatf("bp%0d", k), 2'd0, 8'h00, 1'b1, 1'b1);
    end
    oready = 1'b1;
    chk_ready("bp_resume_ready", 4'b0010);
    tick;
    chk_out("bp_resume", 2'd1, 8'h11, 1'b1, 1'b1);
    ivalid = 4'b0000;
    chk_ready("bp_drain_ready", 4'b0000);
    tick;
    chk("bp_drain_ovalid", 32'(ovalid), 32'd0);

    // Port 2 sends a 3-beat packet while port 0 stays valid
    do_reset;
    idata = '0;
    set_data(0, 8'h0F);
    set_data(2, 8'h21);
    ivalid = 4'b0100;
    ilast  = 4'b0000;
    oready = 1'b1;
    chk_ready("pkt1_ready", 4'b0100);
    tick;
    chk_out("pkt1", 2'd2, 8'h21, 1'b0, 1'b1);
`ifdef AXIS_ARB_PACKET_LOCK_EN
    ivalid = 4'b0101;
    set_data(2, 8'h22);
    chk_ready("lk2_ready", 4'b0100);
    tick;
    chk_out("lk2", 2'd2, 8'h22, 1'b0, 1'b1);
    set_data(2, 8'h23);
    ilast = 4'b0100;
    chk_ready("lk3_ready", 4'b0100);
    tick;
    chk_out("lk3", 2'd2, 8'h23, 1'b1, 1'b1);
    ivalid = 4'b0001;
    ilast  = 4'b0000;
    chk_ready("lk4_ready", 4'b0001);
    tick;
    chk_out("lk4", 2'd0, 8'h0F, 1'b0, 1'b1);
    ilast = 4'b0001;
    chk_ready("lk5_ready", 4'b0001);
    tick;
    chk_out("lk5", 2'd0, 8'h0F, 1'b1, 1'b1);
`else
    ivalid = 4'b0101;
    set_data(2, 8'h22);
    chk_ready("il2_ready", 4'b0001);
    tick;
    chk_out("il2", 2'd0, 8'h0F, 1'b0, 1'b1);
    chk_ready("il3_ready", 4'b0100);
    tick;
    chk_out("il3", 2'd2, 8'h22, 1'b0, 1'b1);
    set_data(2, 8'h23);
    ilast = 4'b0100;
    chk_ready("il4_ready", 4'b0001);
    tick;
    chk_out("il4", 2'd0, 8'h0F, 1'b0, 1'b1);
    chk_ready("il5_ready", 4'b0100);
    tick;
    chk_out("il5", 2'd2, 8'h23, 1'b1, 1'b1);
`endif

    // Reset mid-packet with an undelivered output beat
    do_reset;
    idata = '0;
    set_data(2, 8'h21);
    ivalid = 4'b0100;
    ilast  = 4'b0000;
    oready = 1'b1;
    chk_ready("mr_ready", 4'b0100);
    tick;
    chk_out("mr_pre", 2'd2, 8'h21, 1'b0, 1'b1);
    oready = 1'b0;
    set_data(0, 8'h0F);
    set_data(1, 8'h1F);
    ivalid = 4'b0111;
    reset  = 1'b1;
    tick;
    chk_out("mr_rst", 2'd0, 8'h00, 1'b0, 1'b0);
    reset  = 1'b0;
    oready = 1'b1;
    chk_ready("mr_first_ready", 4'b0001);
    tick;
    chk_out("mr_first", 2'd0, 8'h0F, 1'b0, 1'b1);

    // Only port 3 valid: granted every cycle
    do_reset;
    idata  = '0;
    ivalid = 4'b1000;
    ilast  = 4'b1000;
    oready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_data(3, 8'(8'h30 + k));
      chk_ready($sformatf("p3_%0d_ready", k), 4'b1000);
      tick;
      chk_out($sformatf("p3_%0d", k), 2'd3, 8'(8'h30 + k), 1'b1, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
